// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    S_CORE = 1'b0,
    S_HOST = 1'b1
  } arb_state_t;

  localparam logic [3:0] WSTRB_NONE = 4'b0000;
  localparam logic [3:0] WSTRB_WORD = 4'b1111;

  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned BURST_LEN_DEF  = 2;

  // Width of a counter that ranges over 0..max_count-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count <= 1) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/dmem_arb_fsm.sv
// Arbitration FSM: tracks host starvation in S_CORE and bounds forced host
// bursts in S_HOST. host_sel and host_phase are combinational from the
// registered state and the live request lines so the core sees no latency.
module dmem_arb_fsm
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned BURST_LEN  = BURST_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic c_req,
  input  logic h_req,
  output logic host_sel,
  output logic host_phase
);

  localparam int unsigned WAIT_W = cnt_width(STARVE_MAX);
  localparam int unsigned BEAT_W = cnt_width(BURST_LEN);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STARVE_MAX - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  arb_state_t        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [BEAT_W-1:0] beat_cnt;

  // State and counter update; counters are cleared on every transition so
  // they never wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_CORE;
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        S_CORE: begin
          if (c_req && h_req) begin
            if (wait_cnt == WAIT_LAST) begin
              state    <= S_HOST;
              wait_cnt <= '0;
              beat_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end else begin
            // Host idle or served in an idle slot: starvation resets.
            wait_cnt <= '0;
          end
        end
        S_HOST: begin
          if (h_req && (beat_cnt != BEAT_LAST)) begin
            beat_cnt <= beat_cnt + 1'b1;
          end else begin
            // Last beat granted, or host released early.
            state    <= S_CORE;
            beat_cnt <= '0;
          end
        end
        default: begin
          state    <= S_CORE;
          wait_cnt <= '0;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  // Host wins in S_HOST whenever it asks, and in S_CORE only on idle slots.
  always_comb begin
    host_phase = (state == S_HOST);
    host_sel   = host_phase ? h_req : (h_req && !c_req);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter between the core load/store port and a host
// port. Optional macro DMEM_ARB_PERF_EN adds stall / host-beat counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned BURST_LEN  = BURST_LEN_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic [3:0]  c_wstrb,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_stall,
  input  logic        h_req,
  input  logic [3:0]  h_wstrb,
  input  logic [31:0] h_addr,
  input  logic [31:0] h_wdata,
  output logic        h_gnt,
  output logic        h_rvalid,
  output logic [31:0] h_rdata,
  output logic [3:0]  ram_wstrb,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_host_cnt
`endif
);

  logic host_sel;
  logic host_phase;
  logic core_sel;

  dmem_arb_fsm #(
    .STARVE_MAX (STARVE_MAX),
    .BURST_LEN  (BURST_LEN)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .c_req      (c_req),
    .h_req      (h_req),
    .host_sel   (host_sel),
    .host_phase (host_phase)
  );

  assign core_sel = c_req && !host_phase;
  assign c_stall  = c_req && host_phase;
  assign h_gnt    = host_sel;
  assign c_rdata  = ram_rdata;

  // RAM port mux: the granted side drives the RAM, otherwise it is idle.
  always_comb begin
    ram_wstrb = WSTRB_NONE;
    ram_addr  = '0;
    ram_wdata = '0;
    if (host_sel) begin
      ram_wstrb = h_wstrb;
      ram_addr  = h_addr;
      ram_wdata = h_wdata;
    end else if (core_sel) begin
      ram_wstrb = c_wstrb;
      ram_addr  = c_addr;
      ram_wdata = c_wdata;
    end
  end

  // Host read return: capture RAM data one cycle after a granted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_rvalid <= 1'b0;
      h_rdata  <= '0;
    end else begin
      h_rvalid <= host_sel && (h_wstrb == WSTRB_NONE);
      if (host_sel && (h_wstrb == WSTRB_NONE)) begin
        h_rdata <= ram_rdata;
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  // Free-running performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_host_cnt  <= '0;
    end else begin
      if (c_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (h_gnt)   perf_host_cnt  <= perf_host_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model with a shadow memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int STARVE = 4;
  localparam int BURST  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req;
  logic [3:0]  c_wstrb;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        c_stall;
  logic        h_req;
  logic [3:0]  h_wstrb;
  logic [31:0] h_addr, h_wdata;
  logic        h_gnt, h_rvalid;
  logic [31:0] h_rdata;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_cnt, perf_host_cnt;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_MAX(STARVE), .BURST_LEN(BURST)) dut (
    .clk       (clk),
    .reset     (reset),
    .c_req     (c_req),
    .c_wstrb   (c_wstrb),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_rdata   (c_rdata),
    .c_stall   (c_stall),
    .h_req     (h_req),
    .h_wstrb   (h_wstrb),
    .h_addr    (h_addr),
    .h_wdata   (h_wdata),
    .h_gnt     (h_gnt),
    .h_rvalid  (h_rvalid),
    .h_rdata   (h_rdata),
    .ram_wstrb (ram_wstrb),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_host_cnt  (perf_host_cnt)
`endif
  );

  // RAM driven by the DUT, and an independent shadow kept by the model.
  logic [31:0] mem    [0:63];
  logic [31:0] shadow [0:63];

  assign ram_rdata = mem[ram_addr[7:2]];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_wstrb[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: arbitration mode, starvation and burst counts as ints.
  bit          m_host;
  int          m_wait, m_beat;
  bit          m_rv;
  logic [31:0] m_hrdata;
  int unsigned m_ps, m_ph;
  bit          m_last_hgnt;

  // Observations captured for directed checks.
  logic        obs_stall, obs_gnt, obs_rvalid;
  logic [31:0] obs_hrdata, obs_crdata;
  logic [31:0] obs_ps, obs_ph;

  task automatic model_reset();
    m_host = 0; m_wait = 0; m_beat = 0; m_rv = 0; m_hrdata = '0; m_ps = 0; m_ph = 0;
  endtask

  // One clock: compare the DUT against the model mid-cycle, then advance.
  task automatic cycle();
    bit          core_g, host_g, stall;
    logic [3:0]  e_wstrb;
    logic [31:0] e_addr, e_wdata;
    @(negedge clk);
    host_g  = m_host ? h_req : (h_req && !c_req);
    core_g  = c_req && !m_host;
    stall   = c_req && m_host;
    e_wstrb = 4'h0; e_addr = '0; e_wdata = '0;
    if (host_g) begin
      e_wstrb = h_wstrb; e_addr = h_addr; e_wdata = h_wdata;
    end else if (core_g) begin
      e_wstrb = c_wstrb; e_addr = c_addr; e_wdata = c_wdata;
    end
    check_eq("c_stall",   {31'd0, c_stall},  {31'd0, stall});
    check_eq("h_gnt",     {31'd0, h_gnt},    {31'd0, host_g});
    check_eq("ram_wstrb", {28'd0, ram_wstrb}, {28'd0, e_wstrb});
    check_eq("ram_addr",  ram_addr,  e_addr);
    check_eq("ram_wdata", ram_wdata, e_wdata);
    check_eq("h_rvalid",  {31'd0, h_rvalid}, {31'd0, m_rv});
    check_eq("h_rdata",   h_rdata,   m_hrdata);
    if (core_g) check_eq("c_rdata", c_rdata, shadow[c_addr[7:2]]);
`ifdef DMEM_ARB_PERF_EN
    check_eq("perf_stall", perf_stall_cnt, m_ps);
    check_eq("perf_host",  perf_host_cnt,  m_ph);
    obs_ps = perf_stall_cnt; obs_ph = perf_host_cnt;
`else
    obs_ps = '0; obs_ph = '0;
`endif
    obs_stall = c_stall; obs_gnt = h_gnt; obs_rvalid = h_rvalid;
    obs_hrdata = h_rdata; obs_crdata = c_rdata;
    if (host_g)
      $display("[TB] host %s addr=%h data=%h", (h_wstrb == WSTRB_NONE) ? "rd" : "wr",
               h_addr, (h_wstrb == WSTRB_NONE) ? shadow[h_addr[7:2]] : h_wdata);
    m_last_hgnt = host_g;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (stall)  m_ps++;
      if (host_g) m_ph++;
      m_rv = host_g && (h_wstrb == WSTRB_NONE);
      if (m_rv) m_hrdata = shadow[h_addr[7:2]];
      if (!m_host) begin
        if (c_req && h_req) begin
          if (m_wait + 1 == STARVE) begin m_host = 1; m_wait = 0; m_beat = 0; end
          else m_wait++;
        end else m_wait = 0;
      end else begin
        if (h_req) m_beat++;
        if (!h_req || m_beat == BURST) begin m_host = 0; m_beat = 0; end
      end
    end
    if (e_wstrb != 4'h0) shadow[e_addr[7:2]] = merge(shadow[e_addr[7:2]], e_wdata, e_wstrb);
    #1;
  endtask

  task automatic drive(input bit cr, input logic [3:0] cs, input logic [31:0] ca,
                       input logic [31:0] cd, input bit hr, input logic [3:0] hs,
                       input logic [31:0] ha, input logic [31:0] hd);
    c_req = cr; c_wstrb = cs; c_addr = ca; c_wdata = cd;
    h_req = hr; h_wstrb = hs; h_addr = ha; h_wdata = hd;
  endtask

  logic [11:0] pat;
  logic [31:0] ps0, ph0;
  bit          h_pend;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom; shadow[i] = mem[i];
    end
    mem[16] = 32'h0BAD_F00D; shadow[16] = 32'h0BAD_F00D;
    reset = 1'b1;
    drive(0, 4'h0, 0, 0, 0, 4'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Core only: write then read back 0x10.
    drive(1, WSTRB_WORD, 32'h10, 32'h1234_5678, 0, 4'h0, 0, 0);
    cycle();
    check_eq("core_wr_stall", {31'd0, obs_stall}, 32'd0);
    check_eq("core_wr_gnt",   {31'd0, obs_gnt},   32'd0);
    drive(1, WSTRB_NONE, 32'h10, 0, 0, 4'h0, 0, 0);
    cycle();
    check_eq("core_rd_data",  obs_crdata, 32'h1234_5678);
    check_eq("core_rd_stall", {31'd0, obs_stall}, 32'd0);

    // Idle-slot host read of 0x20.
    drive(0, 4'h0, 0, 0, 1, WSTRB_NONE, 32'h20, 0);
    cycle();
    check_eq("idle_gnt", {31'd0, obs_gnt}, 32'd1);
    drive(0, 4'h0, 0, 0, 0, 4'h0, 0, 0);
    cycle();
    check_eq("idle_rvalid", {31'd0, obs_rvalid}, 32'd1);
    check_eq("idle_rdata",  obs_hrdata, shadow[8]);
    cycle();
    check_eq("idle_rvalid_drop", {31'd0, obs_rvalid}, 32'd0);

    // Starvation: core 4, host 2, core 4, host 2; host write lands only on host beats.
    pat = 12'b1100_0011_0000;
    ps0 = '0; ph0 = '0;
    for (int k = 0; k < 12; k++) begin
      drive(1, WSTRB_NONE, 32'h40, 0, 1, WSTRB_WORD, 32'h40, 32'hDEAD_BEEF);
      cycle();
      if (k == 0) begin ps0 = obs_ps; ph0 = obs_ph; end
      check_eq("starve_stall", {31'd0, obs_stall}, {31'd0, pat[k]});
      check_eq("starve_gnt",   {31'd0, obs_gnt},   {31'd0, pat[k]});
      if (k < 4) check_eq("starve_pre_data", obs_crdata, 32'h0BAD_F00D);
      if (k >= 6 && k < 10) check_eq("starve_post_data", obs_crdata, 32'hDEAD_BEEF);
    end
    drive(1, WSTRB_NONE, 32'h40, 0, 0, 4'h0, 0, 0);
    cycle();
`ifdef DMEM_ARB_PERF_EN
    check_eq("perf_stall_12", obs_ps - ps0, 32'd4);
    check_eq("perf_host_12",  obs_ph - ph0, 32'd4);
`endif

    // Early release: one host beat, then host drops its request.
    for (int k = 0; k < 4; k++) begin
      drive(1, WSTRB_NONE, 0, 0, 1, WSTRB_WORD, 32'h44, 32'hA5A5_0001);
      cycle();
    end
    drive(1, WSTRB_NONE, 0, 0, 1, WSTRB_WORD, 32'h44, 32'hA5A5_0001);
    cycle();
    check_eq("early_beat_gnt", {31'd0, obs_gnt}, 32'd1);
    drive(1, WSTRB_NONE, 0, 0, 0, 4'h0, 0, 0);
    cycle();
    cycle();
    check_eq("early_core_stall", {31'd0, obs_stall}, 32'd0);

    // Reset in the first host read beat of a forced burst.
    for (int k = 0; k < 4; k++) begin
      drive(1, WSTRB_NONE, 0, 0, 1, WSTRB_NONE, 32'h20, 0);
      cycle();
    end
    reset = 1'b1;
    cycle();
    check_eq("rst_beat_gnt", {31'd0, obs_gnt}, 32'd1);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (k == 0) check_eq("rst_rvalid", {31'd0, obs_rvalid}, 32'd0);
      check_eq("rst_starve", {31'd0, obs_stall}, (k == 4) ? 32'd1 : 32'd0);
    end
    drive(0, 4'h0, 0, 0, 0, 4'h0, 0, 0);
    repeat (2) cycle();

    // Randomized traffic against the model.
    h_pend = 0;
    for (int n = 0; n < 800; n++) begin
      if (!h_pend && $urandom_range(0, 2) == 0) begin
        h_pend  = 1;
        h_addr  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        h_wdata = $urandom;
        case ($urandom_range(0, 2))
          0:       h_wstrb = WSTRB_NONE;
          1:       h_wstrb = WSTRB_WORD;
          default: h_wstrb = 4'($urandom);
        endcase
      end
      h_req   = h_pend;
      c_req   = ($urandom_range(0, 3) != 0);
      c_wstrb = ($urandom_range(0, 1) == 0) ? WSTRB_NONE : 4'($urandom);
      c_addr  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      c_wdata = $urandom;
      reset   = ($urandom_range(0, 149) == 0);
      cycle();
      if (m_last_hgnt) h_pend = 0;
    end
    reset = 1'b0;

    for (int i = 0; i < 64; i++) check_eq("final_mem", mem[i], shadow[i]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
